pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register that generalises the fixed ID/EX latch into a reusable valid/ready stage for any boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data payload, and supports back-pressure (stall), synchronous flush and bubble masking of control bits. An optional two-entry skid buffer fully registers the ready path. A saturating stall counter is included for performance monitoring.

Parameters:
CTRL_WIDTH, 8, width of control bundle (ID/EX default: ALUop[1:0], ALUsrc, isBranch, memRead, memWrite, regWrite, memToReg)
PAYLOAD_WIDTH, 282, width of data payload (ID/EX default: PC, regData1, regData2, signExtend 4x64, ALUcontrol 11, Rm/Rn/writeReg 3x5)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_WIDTH, 16, width of stall counter

Ports:
CLOCK  input  1  rising-edge clock
RESET  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of all held entries (branch taken / exception)
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept this cycle
in_ctrl  input  CTRL_WIDTH  upstream control bundle
in_payload  input  PAYLOAD_WIDTH  upstream data
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_WIDTH  control bundle; forced to 0 when out_valid=0
out_payload  output  PAYLOAD_WIDTH  data (don't-care when out_valid=0)
occupancy  output  2  held entries (0..2; max 1 when SKID=0)
stall_count  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (synchronous, RESET=1 at edge): state EMPTY; main/skid ctrl and payload registers = 0; out_valid=0; out_ctrl=0; occupancy=0; stall_count=0. in_ready=1 in the first cycle after reset.
- Priority at each edge: RESET > flush > normal operation.
- SKID=1 state machine (main register M, skid register S):
  - EMPTY: in_fire -> ONE, M<=in.
  - ONE: in_fire & out_fire -> ONE, M<=in. in_fire & !out_fire -> TWO, S<=in. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: out_fire -> ONE, M<=S. No in_fire is possible here.
  - in_ready = registered (state != TWO), so in_ready has no combinational path from out_ready.
  - out_valid = (state != EMPTY); out_ctrl/out_payload come from M.
- SKID=0 mode: single register M. in_ready = !out_valid | out_ready (combinational). in_fire loads M and sets out_valid=1. out_fire without in_fire clears out_valid.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Order is strictly FIFO. No entry is dropped or duplicated except on flush.
- flush: next state EMPTY, occupancy=0, out_valid=0 in the following cycle. An in_fire in the same cycle as flush is discarded. An out_fire in the flush cycle still counts as delivered downstream. Payload registers need not be cleared; ctrl registers are cleared.
- Bubble masking: out_ctrl = M.ctrl AND out_valid (replicated), so regWrite/memWrite can never assert on a bubble.
- stall_count: +1 on each cycle with out_valid & !out_ready; holds at 2^CNT_WIDTH-1. Cleared only by RESET, not by flush.
- occupancy: 0/1/2 for EMPTY/ONE/TWO, registered.

Test Plan:
- Reset then stream: RESET=1 for 2 cycles, then in_valid=1 with payloads 1..8 and out_ready=1 constantly -> in_ready=1 throughout; out_valid rises 1 cycle after the first in_fire; outputs 1..8 in order, one per cycle; occupancy=1; stall_count=0.
- Back-pressure (SKID=1): stream 1..4 with out_ready=0 from cycle 2 -> M=1, S=2, occupancy=2, in_ready=0 the cycle after S fills; 3 held upstream; releasing out_ready delivers 1,2,3,4 with no loss; stall_count equals the number of stalled cycles.
- Flush with simultaneous input: occupancy=2, assert flush with in_valid=1 and payload 0xAA -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xAA never appears on the output.
- SKID=0 stall: out_valid=1, out_ready=0, in_valid=1 -> in_ready=0 in the same cycle; set out_ready=1 -> in_ready=1 combinationally, and the held entry is replaced next cycle.
- Bubble masking: in_ctrl=8'hFF with in_valid=0 for 3 cycles -> out_ctrl=0, out_valid=0; with in_valid=1 -> out_ctrl=8'hFF one cycle later.
- Saturation: CNT_WIDTH=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count=15 and stays there; mid-test flush leaves it at 15; RESET clears it to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline-stage register with optional two-entry skid buffer,
// synchronous flush, bubble masking of control bits and a saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_WIDTH    = 8,
  parameter int PAYLOAD_WIDTH = 282,
  parameter int SKID          = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_WIDTH-1:0]    in_ctrl,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_WIDTH-1:0]    out_ctrl,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic [1:0]               occupancy,
  output logic [CNT_WIDTH-1:0]     stall_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]               state;
  logic [1:0]               nextState;
  logic                     inReadyQ;
  logic [CTRL_WIDTH-1:0]    mainCtrl;
  logic [CTRL_WIDTH-1:0]    skidCtrl;
  logic [PAYLOAD_WIDTH-1:0] mainPayload;
  logic [PAYLOAD_WIDTH-1:0] skidPayload;
  logic [CNT_WIDTH-1:0]     stallCount;
  logic                     inFire;
  logic                     outFire;
  logic                     loadMainIn;
  logic                     loadMainSkid;
  logic                     loadSkid;

  assign out_valid   = (state != EMPTY);
  assign inFire      = in_valid && in_ready;
  assign outFire     = out_valid && out_ready;
  assign occupancy   = state;
  assign stall_count = stallCount;
  assign out_payload = mainPayload;
  // Bubbles must never leak regWrite/memWrite downstream.
  assign out_ctrl    = mainCtrl & {CTRL_WIDTH{out_valid}};

  generate
    if (SKID != 0) begin : gSkidReady
      assign in_ready = inReadyQ;
    end else begin : gPassReady
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    nextState    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (state)
      EMPTY: begin
        if (inFire) begin
          nextState  = ONE;
          loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          loadMainIn = 1'b1;
        end else if (inFire && (SKID != 0)) begin
          nextState = TWO;
          loadSkid  = 1'b1;
        end else if (outFire) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        if (outFire) begin
          nextState    = ONE;
          loadMainSkid = 1'b1;
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= EMPTY;
      inReadyQ    <= 1'b1;
      mainCtrl    <= '0;
      skidCtrl    <= '0;
      mainPayload <= '0;
      skidPayload <= '0;
    end else if (flush) begin
      // NOTE: payload holds its stale value on flush; only ctrl must be clean.
      state    <= EMPTY;
      inReadyQ <= 1'b1;
      mainCtrl <= '0;
      skidCtrl <= '0;
    end else begin
      state    <= nextState;
      inReadyQ <= (nextState != TWO);
      if (loadMainIn) begin
        mainCtrl    <= in_ctrl;
        mainPayload <= in_payload;
      end else if (loadMainSkid) begin
        mainCtrl    <= skidCtrl;
        mainPayload <= skidPayload;
      end
      if (loadSkid) begin
        skidCtrl    <= in_ctrl;
        skidPayload <= in_payload;
      end
    end
  end

  // Performance counter survives flush; only RESET clears it.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      stallCount <= '0;
    end else if (out_valid && !out_ready && (stallCount != {CNT_WIDTH{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid instance (4-bit counter) and a pass-through instance from one stimulus
// stream and checks both against a FIFO-level model, plus directed literal checks.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int PW = 16;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic [CW-1:0] inCtrl = '0;
  logic [PW-1:0] inPayload = '0;
  logic          outReady = 1'b0;

  logic          inReady0, outValid0, inReady1, outValid1;
  logic [CW-1:0] outCtrl0, outCtrl1;
  logic [PW-1:0] outPayload0, outPayload1;
  logic [1:0]    occ0, occ1;
  logic [3:0]    stall0;
  logic [15:0]   stall1;

  int  nCompared = 0;
  int  nMismatched = 0;
  bit  checkEn = 1'b0;

  // Model: per instance a FIFO of {ctrl,payload} entries, its size and a stall tally.
  logic [CW+PW-1:0] mQ [2][2];
  int               mSize [2] = '{0, 0};
  int               mStall [2] = '{0, 0};
  int               mStallMax [2] = '{15, 65535};

  always #5 CLOCK = ~CLOCK;

  pipe_stage_reg #(.CTRL_WIDTH(CW), .PAYLOAD_WIDTH(PW), .SKID(1), .CNT_WIDTH(4)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .flush(flush),
    .in_valid(inValid), .in_ready(inReady0), .in_ctrl(inCtrl), .in_payload(inPayload),
    .out_valid(outValid0), .out_ready(outReady), .out_ctrl(outCtrl0), .out_payload(outPayload0),
    .occupancy(occ0), .stall_count(stall0)
  );

  pipe_stage_reg #(.CTRL_WIDTH(CW), .PAYLOAD_WIDTH(PW), .SKID(0), .CNT_WIDTH(16)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .flush(flush),
    .in_valid(inValid), .in_ready(inReady1), .in_ctrl(inCtrl), .in_payload(inPayload),
    .out_valid(outValid1), .out_ready(outReady), .out_ctrl(outCtrl1), .out_payload(outPayload1),
    .occupancy(occ1), .stall_count(stall1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit mReady(input int k);
    if (k == 0) return mSize[0] < 2;
    return (mSize[1] == 0) || outReady;
  endfunction

  always @(posedge CLOCK) begin
    for (int k = 0; k < 2; k++) begin
      bit inF, outF;
      inF  = inValid && mReady(k);
      outF = (mSize[k] > 0) && outReady;
      if (RESET) begin
        mSize[k]  = 0;
        mStall[k] = 0;
      end else begin
        if ((mSize[k] > 0) && !outReady && (mStall[k] < mStallMax[k])) mStall[k]++;
        if (flush) begin
          mSize[k] = 0;
        end else begin
          if (outF) begin
            mQ[k][0] = mQ[k][1];
            mSize[k]--;
          end
          if (inF) begin
            mQ[k][mSize[k]] = {inCtrl, inPayload};
            mSize[k]++;
          end
        end
      end
    end
  end

  task automatic cmpOne(input int k, input logic ir, input logic ov, input logic [CW-1:0] oc,
                        input logic [PW-1:0] op, input logic [1:0] oq, input logic [15:0] sc);
    string tag;
    logic [CW+PW-1:0] head;
    tag  = (k == 0) ? "skid" : "pass";
    head = mQ[k][0];
    check({tag, ".in_ready"},  64'(ir), 64'(mReady(k)));
    check({tag, ".out_valid"}, 64'(ov), 64'(mSize[k] > 0));
    check({tag, ".occupancy"}, 64'(oq), 64'(mSize[k]));
    check({tag, ".stall"},     64'(sc), 64'(mStall[k]));
    check({tag, ".out_ctrl"},  64'(oc), (mSize[k] > 0) ? 64'(head[CW+PW-1:PW]) : 64'd0);
    if (mSize[k] > 0) check({tag, ".out_payload"}, 64'(op), 64'(head[PW-1:0]));
  endtask

  always @(negedge CLOCK) begin
    if (checkEn) begin
      cmpOne(0, inReady0, outValid0, outCtrl0, outPayload0, occ0, {12'd0, stall0});
      cmpOne(1, inReady1, outValid1, outCtrl1, outPayload1, occ1, stall1);
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic drive(input logic iv, input logic [CW-1:0] c, input logic [PW-1:0] p,
                       input logic ordy, input logic fl);
    inValid = iv; inCtrl = c; inPayload = p; outReady = ordy; flush = fl;
    tick();
  endtask

  initial begin
    // Reset for two cycles.
    RESET = 1'b1;
    tick();
    checkEn = 1'b1;
    tick();
    RESET = 1'b0;
    check("reset.out_valid", 64'(outValid0), 64'd0);
    check("reset.occupancy", 64'(occ0), 64'd0);
    check("reset.stall",     64'(stall0), 64'd0);
    check("reset.in_ready",  64'(inReady0), 64'd1);
    check("reset.out_ctrl",  64'(outCtrl0), 64'd0);

    // Stream 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 16'(i), 1'b1, 1'b0);
      check("stream.payload", 64'(outPayload0), 64'(i));
      check("stream.occ",     64'(occ0), 64'd1);
      check("stream.ready",   64'(inReady0), 64'd1);
    end
    drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    check("stream.stall", 64'(stall0), 64'd0);

    // Back-pressure on the skid stage.
    drive(1'b1, 8'h01, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 16'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h03, 16'd3, 1'b0, 1'b0);
    check("bp.occ",     64'(occ0), 64'd2);
    check("bp.ready",   64'(inReady0), 64'd0);
    check("bp.head",    64'(outPayload0), 64'd1);
    check("bp.stall",   64'(stall0), 64'd4);
    drive(1'b1, 8'h03, 16'd3, 1'b1, 1'b0);
    check("bp.drain2",  64'(outPayload0), 64'd2);
    drive(1'b1, 8'h03, 16'd3, 1'b1, 1'b0);
    check("bp.drain3",  64'(outPayload0), 64'd3);
    drive(1'b1, 8'h04, 16'd4, 1'b1, 1'b0);
    check("bp.drain4",  64'(outPayload0), 64'd4);
    drive(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    check("bp.empty",   64'(occ0), 64'd0);

    // Flush while full with a simultaneous input that must be discarded.
    drive(1'b1, 8'h5A, 16'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 16'h22, 1'b0, 1'b0);
    check("flush.occ_before", 64'(occ0), 64'd2);
    drive(1'b1, 8'hC3, 16'hAA, 1'b0, 1'b1);
    check("flush.out_valid", 64'(outValid0), 64'd0);
    check("flush.out_ctrl",  64'(outCtrl0), 64'd0);
    check("flush.occ",       64'(occ0), 64'd0);
    check("flush.in_ready",  64'(inReady0), 64'd1);
    check("flush.stall",     64'(stall0), 64'd6);
    drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    check("flush.no_aa",     64'(outValid0), 64'd0);

    // Pass-through stage: in_ready follows out_ready combinationally.
    drive(1'b1, 8'h01, 16'h55, 1'b1, 1'b0);
    check("pass.held", 64'(outPayload1), 64'h55);
    inValid = 1'b1; inCtrl = 8'h02; inPayload = 16'h66; outReady = 1'b0;
    #1;
    check("pass.ready_low", 64'(inReady1), 64'd0);
    outReady = 1'b1;
    #1;
    check("pass.ready_high", 64'(inReady1), 64'd1);
    @(posedge CLOCK);
    #2;
    check("pass.replaced", 64'(outPayload1), 64'h66);

    // Bubble masking.
    drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'hFF, 16'h0, 1'b1, 1'b0);
      check("bubble.ctrl",  64'(outCtrl0), 64'd0);
      check("bubble.valid", 64'(outValid0), 64'd0);
    end
    drive(1'b1, 8'hFF, 16'h9, 1'b1, 1'b0);
    check("bubble.ctrl_live", 64'(outCtrl0), 64'hFF);
    drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);

    // Saturating stall counter, immune to flush, cleared by RESET.
    drive(1'b1, 8'h10, 16'h77, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
    check("sat.max", 64'(stall0), 64'd15);
    drive(1'b0, 8'h00, 16'h0, 1'b0, 1'b1);
    check("sat.after_flush", 64'(stall0), 64'd15);
    check("sat.flushed",     64'(outValid0), 64'd0);
    RESET = 1'b1;
    drive(1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
    RESET = 1'b0;
    check("sat.reset", 64'(stall0), 64'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 255) == 0);
      drive($urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    RESET = 1'b0;
    drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
    @(negedge CLOCK);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
